spi_byte_master: RTL

- Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. Drives the ss/clk/mosi pins of the expander's SPI slave port and captures its miso.
- Sits on the host/test side of the expander. It turns a valid/ready byte stream into framed SPI transfers and returns each received byte with a one-cycle strobe.
- All logic runs on one system clock. The SPI clock is derived internally by a divider.

---
 rtl/spi_byte_master_if.sv | 37 +++
 rtl/spi_byte_master.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master_if.sv
// spi_byte_master_if: host byte stream and SPI pin bundle for spi_byte_master.
//
// Signals:
//   tx_data  [7:0]  byte to send; sampled only on the accept cycle
//   tx_valid        tx_data is valid
//   tx_ready        master can accept a byte (accept = tx_valid & tx_ready)
//   rx_data  [7:0]  last byte received; held until the next rx_valid
//   rx_valid        one-cycle strobe, rx_data updated in the same cycle
//   busy            master is not idle
//   spi_ss          slave select, active-low
//   spi_sclk        SPI clock, idles low
//   spi_mosi        serial data out
//   spi_miso        serial data in
//
// Modports: master (the SPI master block), slave (host/pin-side environment).
interface spi_byte_master_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       spi_ss;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_miso;

    modport master (
        input  tx_data, tx_valid, spi_miso,
        output tx_ready, rx_data, rx_valid, busy, spi_ss, spi_sclk, spi_mosi
    );

    modport slave (
        output tx_data, tx_valid, spi_miso,
        input  tx_ready, rx_data, rx_valid, busy, spi_ss, spi_sclk, spi_mosi
    );
endinterface

// File: rtl/spi_byte_master.sv
// spi_byte_master: single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Turns a valid/ready byte stream into framed SPI transfers and returns each
// received byte with a one-cycle rx_valid strobe. SCLK is divided from clk.
//
// Parameters:
//   CLK_DIV  SCLK half-period in clk cycles (1..255)
//   SS_GAP   clk cycles spent in the inter-frame gap state (1..255)
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous reset, active-high
//   bus_io  spi_byte_master_if.master: tx/rx stream, busy and SPI pins
//
// Build option: define SPI_BYTE_MASTER_BURST_EN to let a new byte be accepted
// at the end of HOLD, keeping spi_ss low and skipping the gap.
module spi_byte_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned SS_GAP  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    spi_byte_master_if.master        bus_io
);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
    localparam logic [7:0] GapLast = 8'(SS_GAP - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic       ss_q, ss_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    logic hold_done;
    logic tx_ready;
    logic accept;

    assign hold_done = (state_q == StHold) && (cnt_q == DivLast);

`ifdef SPI_BYTE_MASTER_BURST_EN
    assign tx_ready = !rst && ((state_q == StIdle) || hold_done);
`else
    assign tx_ready = !rst && (state_q == StIdle);
`endif
    assign accept = bus_io.tx_valid && tx_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    tx_sh_d = bus_io.tx_data;
                    mosi_d  = bus_io.tx_data[7];
                    ss_d    = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == DivLast) begin
                    cnt_d   = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StShift: begin
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising edge: sample miso on the same clk edge that raises sclk.
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[6:0], bus_io.spi_miso};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            state_d = StHold;
                        end else begin
                            bit_d   = bit_q + 3'd1;
                            tx_sh_d = {tx_sh_q[6:0], 1'b0};
                            mosi_d  = tx_sh_q[6];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (hold_done) begin
                    cnt_d      = '0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    ss_d       = 1'b1;
                    mosi_d     = 1'b0;
                    state_d    = StGap;
`ifdef SPI_BYTE_MASTER_BURST_EN
                    if (accept) begin
                        // Chain the next byte: ss stays low and SETUP expires after one cycle.
                        ss_d    = 1'b0;
                        tx_sh_d = bus_io.tx_data;
                        mosi_d  = bus_io.tx_data[7];
                        bit_d   = '0;
                        cnt_d   = DivLast;
                        state_d = StSetup;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            ss_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign bus_io.tx_ready = tx_ready;
    assign bus_io.busy     = (state_q != StIdle);
    assign bus_io.spi_ss   = ss_q;
    assign bus_io.spi_sclk = sclk_q;
    assign bus_io.spi_mosi = mosi_q;
    assign bus_io.rx_data  = rx_data_q;
    assign bus_io.rx_valid = rx_valid_q;

endmodule
